// File: rtl/uart_word_dump_pkg.sv
// Shared types and constants for the SDRAM-to-UART word dump path.
package uart_word_dump_pkg;
  localparam int WORD_WIDTH           = 16;
  localparam int UART_DUMP_ADDR_WIDTH = 25;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_e;

  typedef enum logic [2:0] {S_IDLE, S_WORD, S_CSUM, S_CSUM_W, S_DONE} send_state_e;

  typedef enum logic [3:0] {
    B_IDLE, B_HI, B_HI_P, B_HI_W, B_HI_R, B_LO, B_LO_P, B_LO_W, B_LO_R
  } ser_state_e;
endpackage

// File: rtl/uart_word_ser.sv
// Sends one 16-bit word as two bytes (high first) over the uart_tx ready/start_n handshake.
module uart_word_ser
  import uart_word_dump_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [WORD_WIDTH-1:0] i_word,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_byte,
  output logic                  o_tx_start_n,
  output logic                  o_word_sent
);
  ser_state_e            r_state;
  ser_state_e            w_next;
  logic [WORD_WIDTH-1:0] r_word;
  logic [7:0]            r_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= B_IDLE;
    else        r_state <= w_next;
  end

  // Each byte: wait for idle, pulse start, then see ready drop and come back.
  always_comb begin
    w_next = r_state;
    case (r_state)
      B_IDLE:  if (i_valid)     w_next = B_HI;
      B_HI:    if (i_tx_ready)  w_next = B_HI_P;
      B_HI_P:                   w_next = B_HI_W;
      B_HI_W:  if (!i_tx_ready) w_next = B_HI_R;
      B_HI_R:  if (i_tx_ready)  w_next = B_LO;
      B_LO:    if (i_tx_ready)  w_next = B_LO_P;
      B_LO_P:                   w_next = B_LO_W;
      B_LO_W:  if (!i_tx_ready) w_next = B_LO_R;
      B_LO_R:  if (i_tx_ready)  w_next = B_IDLE;
      default:                  w_next = B_IDLE;
    endcase
  end

  always_comb begin
    o_tx_start_n = !((r_state == B_HI_P) || (r_state == B_LO_P));
    o_word_sent  = (r_state == B_LO_R) && i_tx_ready;
    o_tx_byte    = r_byte;
  end

  always_ff @(posedge clk) begin
    if ((r_state == B_IDLE) && i_valid) r_word <= i_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_byte <= 8'h00;
    else if ((r_state == B_HI) && i_tx_ready)  r_byte <= r_word[15:8];
    else if ((r_state == B_LO) && i_tx_ready)  r_byte <= r_word[7:0];
  end
endmodule

// File: rtl/uart_word_dump.sv
// Dumps a range of SDRAM words over UART, high byte first, with an optional additive checksum word.
module uart_word_dump
  import uart_word_dump_pkg::*;
#(
  parameter bit SEND_CHECKSUM = 1'b1,
  parameter int ADDR_WIDTH    = UART_DUMP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [WORD_WIDTH-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic                  dram_refresh_data,
  output logic                  dram_write_en,
  input  logic [WORD_WIDTH-1:0] dram_data,
  input  logic                  dram_data_ready,
  input  logic                  dram_mem_ready,
  output logic [7:0]            uart_tx_byte,
  output logic                  uart_tx_start_n,
  input  logic                  uart_tx_ready
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [WORD_WIDTH-1:0] WORD_ONE = 1;

  fetch_state_e          r_fstate, w_fnext;
  send_state_e           r_sstate, w_snext;
  logic                  r_busy, r_buf_full;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_count, r_idx, r_sent, r_csum, r_buf_word;
  logic                  w_accept, w_load, w_take, w_word_sent, w_ser_valid;
  logic [WORD_WIDTH-1:0] w_ser_word;

  function automatic logic [WORD_WIDTH-1:0] csum_add(input logic [WORD_WIDTH-1:0] a,
                                                     input logic [WORD_WIDTH-1:0] b);
    return a + b;
  endfunction

  assign w_accept      = start && !r_busy;
  assign w_load        = (r_fstate == F_WAIT) && dram_data_ready;
  assign w_take        = (r_sstate == S_IDLE) && r_buf_full;
  assign busy          = r_busy;
  assign dram_addr     = r_addr;
  assign dram_write_en = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fstate <= F_IDLE;
      r_sstate <= S_IDLE;
    end else begin
      r_fstate <= w_fnext;
      r_sstate <= w_snext;
    end
  end

  always_comb begin
    w_fnext = r_fstate;
    case (r_fstate)
      F_IDLE: if (w_accept && (word_count != '0))      w_fnext = F_REQ;
      F_REQ:  if (dram_mem_ready && !r_buf_full)       w_fnext = F_WAIT;
      F_WAIT: if (dram_data_ready)
                w_fnext = ((r_idx + WORD_ONE) == r_count) ? F_IDLE : F_REQ;
      default:                                         w_fnext = F_IDLE;
    endcase
  end

  always_comb begin
    dram_refresh_data = (r_fstate == F_REQ) && dram_mem_ready && !r_buf_full;
  end

  always_comb begin
    w_snext = r_sstate;
    case (r_sstate)
      S_IDLE:
        if (w_accept && (word_count == '0)) w_snext = SEND_CHECKSUM ? S_CSUM : S_DONE;
        else if (r_buf_full)                w_snext = S_WORD;
      S_WORD:
        if (w_word_sent) begin
          if ((r_sent + WORD_ONE) == r_count) w_snext = SEND_CHECKSUM ? S_CSUM : S_DONE;
          else                                w_snext = S_IDLE;
        end
      S_CSUM:   w_snext = S_CSUM_W;
      S_CSUM_W: if (w_word_sent) w_snext = S_DONE;
      S_DONE:   w_snext = S_IDLE;
      default:  w_snext = S_IDLE;
    endcase
  end

  always_comb begin
    done        = (r_sstate == S_DONE);
    w_ser_valid = w_take || (r_sstate == S_CSUM);
    w_ser_word  = (r_sstate == S_CSUM) ? r_csum : r_buf_word;
  end

  // A load and a take in the same edge leave the buffer full with the new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= 1'b0;
      r_buf_full <= 1'b0;
      r_addr     <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_sent     <= '0;
      r_csum     <= '0;
    end else begin
      if (w_accept)                   r_busy <= 1'b1;
      else if (r_sstate == S_DONE)    r_busy <= 1'b0;
      if (w_load)                     r_buf_full <= 1'b1;
      else if (w_take)                r_buf_full <= 1'b0;
      if (w_accept) begin
        r_addr  <= base_addr;
        r_count <= word_count;
        r_idx   <= '0;
        r_sent  <= '0;
        r_csum  <= '0;
      end else begin
        if (w_load) begin
          r_addr <= r_addr + ADDR_ONE;
          r_idx  <= r_idx + WORD_ONE;
          r_csum <= csum_add(r_csum, dram_data);
        end
        if ((r_sstate == S_WORD) && w_word_sent) r_sent <= r_sent + WORD_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) r_buf_word <= dram_data;
  end

  uart_word_ser u_ser (
    .clk          (clk),
    .rst_n        (rst),
    .i_valid      (w_ser_valid),
    .i_word       (w_ser_word),
    .i_tx_ready   (uart_tx_ready),
    .o_tx_byte    (uart_tx_byte),
    .o_tx_start_n (uart_tx_start_n),
    .o_word_sent  (w_word_sent)
  );
endmodule
